vec_acc_resp: RTL and testbench

Vector-side responder for the scalar accelerator interface. Accepts scalar requests (instr, rs1, rs2, instr_id), screens illegal opcodes, buffers accepted requests in a DEPTH-entry reorder buffer (ROB), and issues legal ones in order to the vector decoder under a tag. It collects out-of-order completions from the vector back end and returns exactly one response (err, res, instr_id) per accepted request, in acceptance order.

---
 rtl/vec_acc_resp_if.sv | 55 +++++
 rtl/vec_acc_resp.sv | 159 +++++++++++++++
 tb/tb_vec_acc_resp.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/vec_acc_resp_if.sv
// rtl/vec_acc_resp_if.sv - request, issue, completion and response channels of vec_acc_resp
interface vec_acc_resp_if #(
  parameter int XLEN  = 32,
  parameter int ID_W  = 4,
  parameter int TAG_W = 2
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [31:0]      req_instr_i;
  logic [XLEN-1:0]  req_rs1_i;
  logic [XLEN-1:0]  req_rs2_i;
  logic [ID_W-1:0]  req_id_i;

  logic             issue_valid_o;
  logic             issue_ready_i;
  logic [31:0]      issue_instr_o;
  logic [XLEN-1:0]  issue_rs1_o;
  logic [XLEN-1:0]  issue_rs2_o;
  logic [TAG_W-1:0] issue_tag_o;

  logic             cmpl_valid_i;
  logic [TAG_W-1:0] cmpl_tag_i;
  logic             cmpl_err_i;
  logic [XLEN-1:0]  cmpl_res_i;

  logic             resp_valid_o;
  logic             resp_ready_i;
  logic             resp_err_o;
  logic [XLEN-1:0]  resp_res_o;
  logic [ID_W-1:0]  resp_id_o;

  logic             busy_o;

  modport slave (
    input  req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_id_i,
    output req_ready_o,
    output issue_valid_o, issue_instr_o, issue_rs1_o, issue_rs2_o, issue_tag_o,
    input  issue_ready_i,
    input  cmpl_valid_i, cmpl_tag_i, cmpl_err_i, cmpl_res_i,
    output resp_valid_o, resp_err_o, resp_res_o, resp_id_o,
    input  resp_ready_i,
    output busy_o
  );

  modport master (
    output req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_id_i,
    input  req_ready_o,
    input  issue_valid_o, issue_instr_o, issue_rs1_o, issue_rs2_o, issue_tag_o,
    output issue_ready_i,
    output cmpl_valid_i, cmpl_tag_i, cmpl_err_i, cmpl_res_i,
    input  resp_valid_o, resp_err_o, resp_res_o, resp_id_o,
    output resp_ready_i,
    input  busy_o
  );
endinterface

// File: rtl/vec_acc_resp.sv
// rtl/vec_acc_resp.sv - in-order issue / in-order retire reorder buffer for vector accelerator requests
module vec_acc_resp #(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int ID_W  = 4,
  parameter int XLEN  = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  vec_acc_resp_if.slave bus
);
  localparam int CNT_W = TAG_W + 1;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] iss_q, iss_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] err_q, err_d;
  logic [XLEN-1:0]  res_q   [DEPTH];
  logic [XLEN-1:0]  res_d   [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [XLEN-1:0]  rs1_q   [DEPTH];
  logic [XLEN-1:0]  rs1_d   [DEPTH];
  logic [XLEN-1:0]  rs2_q   [DEPTH];
  logic [XLEN-1:0]  rs2_d   [DEPTH];
  logic [ID_W-1:0]  id_q    [DEPTH];
  logic [ID_W-1:0]  id_d    [DEPTH];

  logic [TAG_W-1:0] alloc_q, alloc_d;
  logic [TAG_W-1:0] issue_q, issue_d;
  logic [TAG_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic accept, issue_fire, issue_skip, retire_fire, cmpl_hit, req_legal;

  // Vector arithmetic opcode always legal; vector loads/stores share the FP
  // load/store opcodes, so only the vector width encodings are accepted there.
  function automatic logic is_legal(input logic [31:0] instr);
    logic [6:0] opc;
    logic [2:0] width;
    opc   = instr[6:0];
    width = instr[14:12];
    if (opc == 7'b1010111) return 1'b1;
    if (opc == 7'b0000111 || opc == 7'b0100111)
      return (width == 3'b000) || (width == 3'b101) || (width == 3'b110) || (width == 3'b111);
    return 1'b0;
  endfunction

  assign req_legal   = is_legal(bus.req_instr_i);
  assign accept      = bus.req_valid_i & bus.req_ready_o;
  assign issue_fire  = bus.issue_valid_o & bus.issue_ready_i;
  assign issue_skip  = vld_q[issue_q] & iss_q[issue_q];
  assign retire_fire = bus.resp_valid_o & bus.resp_ready_i;
  assign cmpl_hit    = bus.cmpl_valid_i & vld_q[bus.cmpl_tag_i] &
                       iss_q[bus.cmpl_tag_i] & ~done_q[bus.cmpl_tag_i];

  assign bus.req_ready_o   = (count_q != CNT_W'(DEPTH));
  assign bus.busy_o        = (count_q != '0);

  assign bus.issue_valid_o = vld_q[issue_q] & ~iss_q[issue_q];
  assign bus.issue_instr_o = instr_q[issue_q];
  assign bus.issue_rs1_o   = rs1_q[issue_q];
  assign bus.issue_rs2_o   = rs2_q[issue_q];
  assign bus.issue_tag_o   = issue_q;

  assign bus.resp_valid_o  = vld_q[retire_q] & done_q[retire_q];
  assign bus.resp_err_o    = err_q[retire_q];
  assign bus.resp_res_o    = res_q[retire_q];
  assign bus.resp_id_o     = id_q[retire_q];

  // The four events always touch distinct slots or distinct fields, so they
  // are applied independently in any order.
  always_comb begin
    vld_d    = vld_q;
    iss_d    = iss_q;
    done_d   = done_q;
    err_d    = err_q;
    res_d    = res_q;
    instr_d  = instr_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    id_d     = id_q;
    alloc_d  = alloc_q;
    issue_d  = issue_q;
    retire_d = retire_q;
    count_d  = count_q;

    if (accept) begin
      vld_d[alloc_q]   = 1'b1;
      iss_d[alloc_q]   = ~req_legal;
      done_d[alloc_q]  = ~req_legal;
      err_d[alloc_q]   = ~req_legal;
      res_d[alloc_q]   = '0;
      instr_d[alloc_q] = bus.req_instr_i;
      rs1_d[alloc_q]   = bus.req_rs1_i;
      rs2_d[alloc_q]   = bus.req_rs2_i;
      id_d[alloc_q]    = bus.req_id_i;
      alloc_d          = alloc_q + 1'b1;
    end

    if (issue_fire) begin
      iss_d[issue_q] = 1'b1;
      issue_d        = issue_q + 1'b1;
    end else if (issue_skip) begin
      issue_d        = issue_q + 1'b1;
    end

    if (cmpl_hit) begin
      done_d[bus.cmpl_tag_i] = 1'b1;
      err_d[bus.cmpl_tag_i]  = bus.cmpl_err_i;
      res_d[bus.cmpl_tag_i]  = bus.cmpl_res_i;
    end

    if (retire_fire) begin
      vld_d[retire_q] = 1'b0;
      retire_d        = retire_q + 1'b1;
    end

    case ({accept, retire_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q    <= '0;
      iss_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      alloc_q  <= '0;
      issue_q  <= '0;
      retire_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i]   <= '0;
        instr_q[i] <= '0;
        rs1_q[i]   <= '0;
        rs2_q[i]   <= '0;
        id_q[i]    <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      iss_q    <= iss_d;
      done_q   <= done_d;
      err_q    <= err_d;
      res_q    <= res_d;
      instr_q  <= instr_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      id_q     <= id_d;
      alloc_q  <= alloc_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_vec_acc_resp.sv
// tb/tb_vec_acc_resp.sv - directed vector-table bench for vec_acc_resp
module tb_vec_acc_resp;
  localparam logic [31:0] L1  = 32'h02008057;
  localparam logic [31:0] L2  = 32'h0200A057;
  localparam logic [31:0] LS  = 32'h00006027;
  localparam logic [31:0] ILL = 32'h00000033;
  localparam logic [31:0] ILF = 32'h00002007;
  localparam logic [31:0] RS2_XOR = 32'hFFFF0000;

  typedef struct {
    logic        rst, rv;
    logic [31:0] instr, rs1;
    logic [3:0]  id;
    logic        ir, cv;
    logic [1:0]  ctag;
    logic        cerr;
    logic [31:0] cres;
    logic        rr;
    logic        e_rdy, e_iv;
    logic [1:0]  e_tag;
    logic [31:0] e_instr, e_rs1;
    logic        e_rv, e_err;
    logic [31:0] e_res;
    logic [3:0]  e_id;
    logic        e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  vec_acc_resp_if #(.XLEN(32), .ID_W(4), .TAG_W(2)) bus ();

  vec_acc_resp #(.DEPTH(4), .TAG_W(2), .ID_W(4), .XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  function automatic vec_t row(input int rst, rv, instr, rs1, id, ir, cv, ctag, cerr, cres, rr,
                               input int e_rdy, e_iv, e_tag, e_instr, e_rs1, e_rv, e_err, e_res, e_id, e_busy);
    vec_t r;
    r.rst = rst[0];   r.rv = rv[0];     r.instr = instr;      r.rs1 = rs1;  r.id = id[3:0];
    r.ir = ir[0];     r.cv = cv[0];     r.ctag = ctag[1:0];   r.cerr = cerr[0];
    r.cres = cres;    r.rr = rr[0];
    r.e_rdy = e_rdy[0]; r.e_iv = e_iv[0]; r.e_tag = e_tag[1:0]; r.e_instr = e_instr; r.e_rs1 = e_rs1;
    r.e_rv = e_rv[0];   r.e_err = e_err[0]; r.e_res = e_res;    r.e_id = e_id[3:0];   r.e_busy = e_busy[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid_i   = 1'b0;
    bus.req_instr_i   = '0;
    bus.req_rs1_i     = '0;
    bus.req_rs2_i     = '0;
    bus.req_id_i      = '0;
    bus.issue_ready_i = 1'b0;
    bus.cmpl_valid_i  = 1'b0;
    bus.cmpl_tag_i    = '0;
    bus.cmpl_err_i    = 1'b0;
    bus.cmpl_res_i    = '0;
    bus.resp_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply_row(input int idx, input vec_t r);
    if (r.rst) do_reset();
    bus.req_valid_i   = r.rv;
    bus.req_instr_i   = r.instr;
    bus.req_rs1_i     = r.rs1;
    bus.req_rs2_i     = r.rs1 ^ RS2_XOR;
    bus.req_id_i      = r.id;
    bus.issue_ready_i = r.ir;
    bus.cmpl_valid_i  = r.cv;
    bus.cmpl_tag_i    = r.ctag;
    bus.cmpl_err_i    = r.cerr;
    bus.cmpl_res_i    = r.cres;
    bus.resp_ready_i  = r.rr;
    #1;
    chk($sformatf("row%0d req_ready", idx),   32'(bus.req_ready_o),   32'(r.e_rdy));
    chk($sformatf("row%0d issue_valid", idx), 32'(bus.issue_valid_o), 32'(r.e_iv));
    chk($sformatf("row%0d resp_valid", idx),  32'(bus.resp_valid_o),  32'(r.e_rv));
    chk($sformatf("row%0d busy", idx),        32'(bus.busy_o),        32'(r.e_busy));
    if (r.e_iv) begin
      chk($sformatf("row%0d issue_tag", idx),   32'(bus.issue_tag_o), 32'(r.e_tag));
      chk($sformatf("row%0d issue_instr", idx), bus.issue_instr_o,    r.e_instr);
      chk($sformatf("row%0d issue_rs1", idx),   bus.issue_rs1_o,      r.e_rs1);
      chk($sformatf("row%0d issue_rs2", idx),   bus.issue_rs2_o,      r.e_rs1 ^ RS2_XOR);
    end
    if (r.e_rv) begin
      chk($sformatf("row%0d resp_err", idx), 32'(bus.resp_err_o), 32'(r.e_err));
      chk($sformatf("row%0d resp_res", idx), bus.resp_res_o,      r.e_res);
      chk($sformatf("row%0d resp_id", idx),  32'(bus.resp_id_o),  32'(r.e_id));
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    // rst rv instr rs1 id | ir cv ctag cerr cres | rr || rdy iv tag instr rs1 | rv err res id | busy
    // single legal, then single illegal
    tv.push_back(row(1,1,L1,32'h11,3, 0,0,0,0,0, 1, 1,0,0,0,0, 0,0,0,0, 0));
    tv.push_back(row(0,0,0,0,0,       1,0,0,0,0, 1, 1,1,0,L1,32'h11, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,       0,1,0,0,5, 1, 1,0,0,0,0, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,       0,0,0,0,0, 1, 1,0,0,0,0, 1,0,5,3, 1));
    tv.push_back(row(0,0,0,0,0,       0,0,0,0,0, 1, 1,0,0,0,0, 0,0,0,0, 0));
    tv.push_back(row(0,1,ILL,32'h77,7,0,0,0,0,0, 0, 1,0,0,0,0, 0,0,0,0, 0));
    tv.push_back(row(0,0,0,0,0,       1,0,0,0,0, 0, 1,0,0,0,0, 1,1,0,7, 1));
    tv.push_back(row(0,0,0,0,0,       0,0,0,0,0, 1, 1,0,0,0,0, 1,1,0,7, 1));
    tv.push_back(row(0,0,0,0,0,       0,0,0,0,0, 0, 1,0,0,0,0, 0,0,0,0, 0));
    // out-of-order completion: tags 2, 0, 1
    tv.push_back(row(1,1,L1,32'h100,1, 1,0,0,0,0, 0, 1,0,0,0,0, 0,0,0,0, 0));
    tv.push_back(row(0,1,L1,32'h200,2, 1,0,0,0,0, 0, 1,1,0,L1,32'h100, 0,0,0,0, 1));
    tv.push_back(row(0,1,L1,32'h300,3, 1,0,0,0,0, 0, 1,1,1,L1,32'h200, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        1,0,0,0,0, 0, 1,1,2,L1,32'h300, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        0,1,2,0,32'h30, 0, 1,0,0,0,0, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        0,1,0,0,32'h10, 1, 1,0,0,0,0, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        0,0,0,0,0, 1, 1,0,0,0,0, 1,0,32'h10,1, 1));
    tv.push_back(row(0,0,0,0,0,        0,1,1,1,32'h20, 1, 1,0,0,0,0, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        0,0,0,0,0, 1, 1,0,0,0,0, 1,1,32'h20,2, 1));
    tv.push_back(row(0,0,0,0,0,        0,0,0,0,0, 1, 1,0,0,0,0, 1,0,32'h30,3, 1));
    tv.push_back(row(0,0,0,0,0,        0,0,0,0,0, 1, 1,0,0,0,0, 0,0,0,0, 0));
    // full with resp backpressure, one retire, wrap to tag 0
    tv.push_back(row(1,1,L1,32'h100,1, 0,0,0,0,0, 0, 1,0,0,0,0, 0,0,0,0, 0));
    tv.push_back(row(0,1,L1,32'h200,2, 0,0,0,0,0, 0, 1,1,0,L1,32'h100, 0,0,0,0, 1));
    tv.push_back(row(0,1,L1,32'h300,3, 0,0,0,0,0, 0, 1,1,0,L1,32'h100, 0,0,0,0, 1));
    tv.push_back(row(0,1,L1,32'h400,4, 0,0,0,0,0, 0, 1,1,0,L1,32'h100, 0,0,0,0, 1));
    tv.push_back(row(0,1,L2,32'h500,5, 0,0,0,0,0, 0, 0,1,0,L1,32'h100, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        1,0,0,0,0, 0, 0,1,0,L1,32'h100, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        0,1,0,0,32'hAA, 0, 0,1,1,L1,32'h200, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        0,0,0,0,0, 1, 0,1,1,L1,32'h200, 1,0,32'hAA,1, 1));
    tv.push_back(row(0,1,L2,32'h500,5, 0,0,0,0,0, 0, 1,1,1,L1,32'h200, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        1,0,0,0,0, 0, 0,1,1,L1,32'h200, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        1,0,0,0,0, 0, 0,1,2,L1,32'h300, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        1,0,0,0,0, 0, 0,1,3,L1,32'h400, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        1,0,0,0,0, 0, 0,1,0,L2,32'h500, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,        0,0,0,0,0, 0, 0,0,0,0,0, 0,0,0,0, 1));
    // mixed: legal, illegal FP-load width, legal vector store
    tv.push_back(row(1,1,L1,32'h100,1,  1,0,0,0,0, 1, 1,0,0,0,0, 0,0,0,0, 0));
    tv.push_back(row(0,1,ILF,32'h200,2, 1,0,0,0,0, 1, 1,1,0,L1,32'h100, 0,0,0,0, 1));
    tv.push_back(row(0,1,LS,32'h300,3,  1,0,0,0,0, 1, 1,0,0,0,0, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,         1,0,0,0,0, 1, 1,1,2,LS,32'h300, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,         1,0,0,0,0, 1, 1,0,0,0,0, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,         1,1,0,0,7, 1, 1,0,0,0,0, 0,0,0,0, 1));
    tv.push_back(row(0,0,0,0,0,         1,0,0,0,0, 1, 1,0,0,0,0, 1,0,7,1, 1));
    tv.push_back(row(0,0,0,0,0,         1,1,2,0,9, 1, 1,0,0,0,0, 1,1,0,2, 1));
    tv.push_back(row(0,0,0,0,0,         1,0,0,0,0, 1, 1,0,0,0,0, 1,0,9,3, 1));
    tv.push_back(row(0,0,0,0,0,         1,0,0,0,0, 1, 1,0,0,0,0, 0,0,0,0, 0));

    @(negedge clk);
    foreach (tv[i]) apply_row(i, tv[i]);

    // reset data outputs, then a completion in its own issue cycle is dropped
    do_reset();
    #1;
    chk("rst req_ready",   32'(bus.req_ready_o), 32'd1);
    chk("rst issue_instr", bus.issue_instr_o,    32'd0);
    chk("rst issue_rs1",   bus.issue_rs1_o,      32'd0);
    chk("rst issue_rs2",   bus.issue_rs2_o,      32'd0);
    chk("rst issue_tag",   32'(bus.issue_tag_o), 32'd0);
    chk("rst resp_err",    32'(bus.resp_err_o),  32'd0);
    chk("rst resp_res",    bus.resp_res_o,       32'd0);
    chk("rst resp_id",     32'(bus.resp_id_o),   32'd0);
    bus.req_valid_i = 1'b1; bus.req_instr_i = L1; bus.req_rs1_i = 32'h900; bus.req_id_i = 4'd9;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1 chk("same-cycle issue_valid", 32'(bus.issue_valid_o), 32'd1);
    bus.issue_ready_i = 1'b1;
    bus.cmpl_valid_i = 1'b1; bus.cmpl_tag_i = 2'd0; bus.cmpl_res_i = 32'h55;
    @(negedge clk);
    bus.issue_ready_i = 1'b0; bus.cmpl_valid_i = 1'b0;
    bus.req_valid_i = 1'b1; bus.req_id_i = 4'd10;
    @(negedge clk);
    bus.req_id_i = 4'd11;
    @(negedge clk);
    bus.req_valid_i = 1'b0; bus.resp_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("dropped cmpl resp_valid c%0d", k), 32'(bus.resp_valid_o), 32'd0);
      chk($sformatf("dropped cmpl busy c%0d", k), 32'(bus.busy_o), 32'd1);
      @(negedge clk);
    end

    // asynchronous reset with three entries outstanding
    rst_n = 1'b0;
    #1;
    chk("midrst req_ready",   32'(bus.req_ready_o),   32'd1);
    chk("midrst issue_valid", 32'(bus.issue_valid_o), 32'd0);
    chk("midrst resp_valid",  32'(bus.resp_valid_o),  32'd0);
    chk("midrst busy",        32'(bus.busy_o),        32'd0);
    chk("midrst issue_instr", bus.issue_instr_o,      32'd0);
    chk("midrst resp_id",     32'(bus.resp_id_o),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cmpl_valid_i = 1'b1; bus.cmpl_tag_i = 2'd1; bus.cmpl_res_i = 32'h66;
    @(negedge clk);
    bus.cmpl_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("post-rst resp_valid c%0d", k), 32'(bus.resp_valid_o), 32'd0);
      chk($sformatf("post-rst busy c%0d", k), 32'(bus.busy_o), 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
